// File: rtl/cache_meta_array.sv
// Tag/valid/dirty/pLRU store for the set-associative data cache with registered lookup,
// fill install and a one-set-per-cycle invalidate-all walk. Optional macro: CACHE_META_DIRTY_EN.
//
// state | meaning
// IDLE  | lookups and fills accepted
// WALK  | clearing set cnt_q each cycle; lookups and fills blocked
module cache_meta_array #(
    parameter int ADDR_W   = 16,
    parameter int OFFSET_W = 2,
    parameter int SETS     = 64,
    parameter int WAYS     = 2
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       req_valid,
    input  logic [ADDR_W-1:0]                          req_addr,
    input  logic                                       req_write,
    output logic                                       req_ready,
    input  logic                                       fill_valid,
    input  logic [ADDR_W-1:0]                          fill_addr,
    input  logic [$clog2(WAYS)-1:0]                    fill_way,
    input  logic                                       fill_dirty,
    input  logic                                       inv_all,
    output logic                                       busy,
    output logic                                       rsp_valid,
    output logic                                       rsp_hit,
    output logic [$clog2(WAYS)-1:0]                    rsp_way,
    output logic                                       rsp_victim_valid,
    output logic [ADDR_W-$clog2(SETS)-OFFSET_W-1:0]    rsp_victim_tag,
    output logic                                       rsp_victim_dirty
);
    localparam int SET_W  = $clog2(SETS);
    localparam int WAY_W  = $clog2(WAYS);
    localparam int TAG_W  = ADDR_W - SET_W - OFFSET_W;
    localparam int PLRU_W = (WAYS == 4) ? 3 : 1;

    typedef enum logic [0:0] {ST_IDLE, ST_WALK} state_t;

    state_t             state_q, state_d;
    logic [SET_W-1:0]   cnt_q, cnt_d;

    logic [TAG_W-1:0]   tag_mem   [SETS][WAYS];
    logic [WAYS-1:0]    valid_mem [SETS];
    logic [PLRU_W-1:0]  plru_mem  [SETS];

    logic [TAG_W-1:0]   req_tag, fill_tag;
    logic [SET_W-1:0]   req_set, fill_set;
    logic               req_fire, fill_fire;
    logic [WAYS-1:0]    valid_row;
    logic [PLRU_W-1:0]  plru_rd, plru_fill_rd, plru_hit_nxt, plru_fill_nxt;
    logic [WAY_W-1:0]   victim_plru, hit_way, inv_way, victim_way;
    logic               hit, inv_found, victim_valid_c, victim_dirty_c;

    logic               rsp_valid_q, rsp_hit_q, rsp_victim_valid_q, rsp_victim_dirty_q;
    logic [WAY_W-1:0]   rsp_way_q;
    logic [TAG_W-1:0]   rsp_victim_tag_q;

    assign req_tag   = req_addr[ADDR_W-1 -: TAG_W];
    assign req_set   = req_addr[OFFSET_W +: SET_W];
    assign fill_tag  = fill_addr[ADDR_W-1 -: TAG_W];
    assign fill_set  = fill_addr[OFFSET_W +: SET_W];

    assign busy      = (state_q == ST_WALK);
    assign req_ready = ~busy & ~fill_valid;
    assign req_fire  = req_valid & req_ready;
    assign fill_fire = fill_valid & ~busy;

    assign valid_row    = valid_mem[req_set];
    assign plru_rd      = plru_mem[req_set];
    assign plru_fill_rd = plru_mem[fill_set];

    generate
        if (WAYS == 4) begin : g_plru4
            assign victim_plru = plru_rd[0] ? {1'b1, plru_rd[2]} : {1'b0, plru_rd[1]};
            always_comb begin
                plru_hit_nxt     = plru_rd;
                plru_hit_nxt[0]  = ~hit_way[1];
                if (!hit_way[1]) plru_hit_nxt[1] = ~hit_way[0];
                else             plru_hit_nxt[2] = ~hit_way[0];
                plru_fill_nxt    = plru_fill_rd;
                plru_fill_nxt[0] = ~fill_way[1];
                if (!fill_way[1]) plru_fill_nxt[1] = ~fill_way[0];
                else              plru_fill_nxt[2] = ~fill_way[0];
            end
        end else begin : g_plru2
            assign victim_plru   = plru_rd;
            assign plru_hit_nxt  = ~hit_way;
            assign plru_fill_nxt = ~fill_way;
        end
    endgenerate

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_row[w] && (tag_mem[req_set][w] == req_tag) && !hit) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_row[w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim_way = inv_found ? inv_way : victim_plru;
    end

    assign victim_valid_c = valid_row[victim_way];

`ifdef CACHE_META_DIRTY_EN
    logic [WAYS-1:0] dirty_mem [SETS];
    assign victim_dirty_c = victim_valid_c & dirty_mem[req_set][victim_way];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) dirty_mem[s] <= '0;
        end else begin
            if (busy) dirty_mem[cnt_q] <= '0;
            if (fill_fire) dirty_mem[fill_set][fill_way] <= fill_dirty;
            if (req_fire && hit && req_write) dirty_mem[req_set][hit_way] <= 1'b1;
        end
    end
`else
    logic unused_dirty;
    assign unused_dirty   = req_write ^ fill_dirty;
    assign victim_dirty_c = 1'b0;
`endif

    logic unused_offset;
    assign unused_offset = ^{req_addr[OFFSET_W-1:0], fill_addr[OFFSET_W-1:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (inv_all) begin
                    state_d = ST_WALK;
                    cnt_d   = '0;
                end
            end
            ST_WALK: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SET_W'(SETS - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Tags need no reset: an invalid way never reports its tag.
    always_ff @(posedge clk) begin
        if (!rst && fill_fire) tag_mem[fill_set][fill_way] <= fill_tag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= ST_IDLE;
            cnt_q              <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_mem[s] <= '0;
                plru_mem[s]  <= '0;
            end
            rsp_valid_q        <= 1'b0;
            rsp_hit_q          <= 1'b0;
            rsp_way_q          <= '0;
            rsp_victim_valid_q <= 1'b0;
            rsp_victim_tag_q   <= '0;
            rsp_victim_dirty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (busy) begin
                valid_mem[cnt_q] <= '0;
                plru_mem[cnt_q]  <= '0;
            end
            if (fill_fire) begin
                valid_mem[fill_set][fill_way] <= 1'b1;
                plru_mem[fill_set]            <= plru_fill_nxt;
            end
            if (req_fire && hit) plru_mem[req_set] <= plru_hit_nxt;

            rsp_valid_q        <= req_fire;
            rsp_hit_q          <= req_fire & hit;
            rsp_way_q          <= !req_fire ? '0 : (hit ? hit_way : victim_way);
            rsp_victim_valid_q <= req_fire & ~hit & victim_valid_c;
            rsp_victim_tag_q   <= (req_fire && !hit && victim_valid_c) ?
                                  tag_mem[req_set][victim_way] : '0;
            rsp_victim_dirty_q <= req_fire & ~hit & victim_dirty_c;
        end
    end

    assign rsp_valid        = rsp_valid_q;
    assign rsp_hit          = rsp_hit_q;
    assign rsp_way          = rsp_way_q;
    assign rsp_victim_valid = rsp_victim_valid_q;
    assign rsp_victim_tag   = rsp_victim_tag_q;
    assign rsp_victim_dirty = rsp_victim_dirty_q;

endmodule

// File: tb/tb_cache_meta_array.sv
// Directed bench for cache_meta_array: a 2-way default instance and a 4-way instance
// checked against hand-computed lookup, victim, pLRU and walk results.
module tb_cache_meta_array;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_write, req_ready, fill_valid, fill_dirty, inv_all, busy;
    logic [15:0] req_addr, fill_addr;
    logic [0:0]  fill_way, rsp_way;
    logic        rsp_valid, rsp_hit, rsp_victim_valid, rsp_victim_dirty;
    logic [7:0]  rsp_victim_tag;

    logic        req_valid4, req_write4, req_ready4, fill_valid4, fill_dirty4, inv_all4, busy4;
    logic [15:0] req_addr4, fill_addr4;
    logic [1:0]  fill_way4, rsp_way4;
    logic        rsp_valid4, rsp_hit4, rsp_victim_valid4, rsp_victim_dirty4;
    logic [7:0]  rsp_victim_tag4;

    int total = 0;
    int bad   = 0;

`ifdef CACHE_META_DIRTY_EN
    localparam logic EXP_D = 1'b1;
`else
    localparam logic EXP_D = 1'b0;
`endif

    cache_meta_array u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_write(req_write), .req_ready(req_ready),
        .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_way(fill_way), .fill_dirty(fill_dirty),
        .inv_all(inv_all), .busy(busy),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
        .rsp_victim_valid(rsp_victim_valid), .rsp_victim_tag(rsp_victim_tag),
        .rsp_victim_dirty(rsp_victim_dirty)
    );

    cache_meta_array #(.WAYS(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid4), .req_addr(req_addr4), .req_write(req_write4), .req_ready(req_ready4),
        .fill_valid(fill_valid4), .fill_addr(fill_addr4), .fill_way(fill_way4), .fill_dirty(fill_dirty4),
        .inv_all(inv_all4), .busy(busy4),
        .rsp_valid(rsp_valid4), .rsp_hit(rsp_hit4), .rsp_way(rsp_way4),
        .rsp_victim_valid(rsp_victim_valid4), .rsp_victim_tag(rsp_victim_tag4),
        .rsp_victim_dirty(rsp_victim_dirty4)
    );

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [15:0] a, input logic w);
        req_valid = 1'b1; req_addr = a; req_write = w;
        step();
        req_valid = 1'b0; req_write = 1'b0;
    endtask

    task automatic fill(input logic [15:0] a, input logic [0:0] way, input logic d);
        fill_valid = 1'b1; fill_addr = a; fill_way = way; fill_dirty = d;
        step();
        fill_valid = 1'b0; fill_dirty = 1'b0;
    endtask

    task automatic lookup4(input logic [15:0] a);
        req_valid4 = 1'b1; req_addr4 = a;
        step();
        req_valid4 = 1'b0;
    endtask

    task automatic fill4(input logic [15:0] a, input logic [1:0] way);
        fill_valid4 = 1'b1; fill_addr4 = a; fill_way4 = way;
        step();
        fill_valid4 = 1'b0;
    endtask

    task automatic check_rsp(input string name, input logic hit, input logic [1:0] way,
                             input logic vv, input logic [7:0] vtag, input logic vd);
        chk({name, " valid"}, rsp_valid, 1'b1);
        chk({name, " hit"}, rsp_hit, hit);
        chk({name, " way"}, rsp_way, way);
        chk({name, " vvalid"}, rsp_victim_valid, vv);
        chk({name, " vtag"}, rsp_victim_tag, vtag);
        chk({name, " vdirty"}, rsp_victim_dirty, vd);
    endtask

    task automatic check_rsp4(input string name, input logic hit, input logic [1:0] way,
                              input logic vv, input logic [7:0] vtag);
        chk({name, " valid"}, rsp_valid4, 1'b1);
        chk({name, " hit"}, rsp_hit4, hit);
        chk({name, " way"}, rsp_way4, way);
        chk({name, " vvalid"}, rsp_victim_valid4, vv);
        chk({name, " vtag"}, rsp_victim_tag4, vtag);
    endtask

    initial begin
        int  n;
        logic rdy_seen;

        rst = 1'b1;
        req_valid = 0; req_addr = '0; req_write = 0;
        fill_valid = 0; fill_addr = '0; fill_way = '0; fill_dirty = 0; inv_all = 0;
        req_valid4 = 0; req_addr4 = '0; req_write4 = 0;
        fill_valid4 = 0; fill_addr4 = '0; fill_way4 = '0; fill_dirty4 = 0; inv_all4 = 0;
        step(); step(); step();
        rst = 1'b0;

        chk("reset rsp_valid", rsp_valid, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset req_ready", req_ready, 1'b1);
        fill_valid = 1'b1;
        #1;
        chk("ready low on fill", req_ready, 1'b0);
        fill_valid = 1'b0;

        // 1: empty cache
        lookup(16'h1234, 1'b0);
        check_rsp("t1", 1'b0, 2'd0, 1'b0, 8'h00, 1'b0);
        step();
        chk("t1 strobe drop", rsp_valid, 1'b0);

        // 2: fill way 0, hit then miss to first invalid way
        fill(16'h1234, 1'b0, 1'b0);
        lookup(16'h1234, 1'b0);
        check_rsp("t2 hit", 1'b1, 2'd0, 1'b0, 8'h00, 1'b0);
        lookup(16'h5634, 1'b0);
        check_rsp("t2 miss", 1'b0, 2'd1, 1'b0, 8'h00, 1'b0);

        // 3: full set, victim from pLRU
        fill(16'h5634, 1'b1, 1'b0);
        lookup(16'h1234, 1'b0);
        check_rsp("t3 hit", 1'b1, 2'd0, 1'b0, 8'h00, 1'b0);
        lookup(16'h9A34, 1'b0);
        check_rsp("t3 miss", 1'b0, 2'd1, 1'b1, 8'h56, 1'b0);

        // 4: store hit sets dirty; back-to-back pLRU updates
        lookup(16'h1234, 1'b1);
        check_rsp("t4 store", 1'b1, 2'd0, 1'b0, 8'h00, 1'b0);
        lookup(16'h5634, 1'b0);
        check_rsp("t4 hit1", 1'b1, 2'd1, 1'b0, 8'h00, 1'b0);
        lookup(16'h9A34, 1'b0);
        check_rsp("t4 miss", 1'b0, 2'd0, 1'b1, 8'h12, EXP_D);

        // fill_dirty path on set 14
        fill(16'h1238, 1'b0, 1'b1);
        fill(16'h5638, 1'b1, 1'b0);
        lookup(16'h9A38, 1'b0);
        check_rsp("fill dirty", 1'b0, 2'd0, 1'b1, 8'h12, EXP_D);

        // 5: invalidate-all walk, second pulse and a fill during the walk are ignored
        inv_all = 1'b1;
        step();
        inv_all = 1'b0;
        chk("walk busy rise", busy, 1'b1);
        n = 0;
        rdy_seen = 1'b0;
        while (busy && n < 200) begin
            rdy_seen = rdy_seen | req_ready;
            inv_all = (n == 10);
            fill_valid = (n == 20);
            fill_addr = 16'h1234; fill_way = 1'b0;
            n++;
            step();
        end
        inv_all = 1'b0;
        fill_valid = 1'b0;
        chk("walk busy cycles", n, 64);
        chk("walk ready low", rdy_seen, 1'b0);
        chk("walk ready after", req_ready, 1'b1);
        lookup(16'h1234, 1'b0);
        check_rsp("t5 set13", 1'b0, 2'd0, 1'b0, 8'h00, 1'b0);
        lookup(16'h9A38, 1'b0);
        check_rsp("t5 set14", 1'b0, 2'd0, 1'b0, 8'h00, 1'b0);

        // 6: 4-way tree pLRU on set 0
        fill4(16'h0100, 2'd0);
        fill4(16'h0200, 2'd1);
        fill4(16'h0300, 2'd2);
        fill4(16'h0400, 2'd3);
        lookup4(16'h0500);
        check_rsp4("t6 miss1", 1'b0, 2'd0, 1'b1, 8'h01);
        lookup4(16'h0100);
        check_rsp4("t6 hit0", 1'b1, 2'd0, 1'b0, 8'h00);
        lookup4(16'h0600);
        check_rsp4("t6 miss2", 1'b0, 2'd2, 1'b1, 8'h03);
        lookup4(16'h0400);
        check_rsp4("t6 hit3", 1'b1, 2'd3, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cache_meta_array.md
# cache_meta_array

Parametrised tag/metadata store for the set-associative data cache: holds tag, valid, dirty and pseudo-LRU state per set, answers registered lookups with hit/way/victim information, installs fills, and runs a multi-cycle invalidate-all walk. It sits between the cache controller FSM and the data array. The controller uses `rsp_way` to index the data array and `rsp_victim_*` to decide on write-back.

## Interface
- `ADDR_W`, 16, byte address width.
- `OFFSET_W`, 2, block offset bits.
- `SETS`, 64, number of sets; power of 2. `SET_W = clog2(SETS)`.
- `WAYS`, 2, associativity; 2 or 4 only. `WAY_W = clog2(WAYS)`.
- Derived: `TAG_W = ADDR_W - SET_W - OFFSET_W`, which is 8 at defaults.
- Address split: tag = `[ADDR_W-1 : SET_W+OFFSET_W]`, set = next `SET_W` bits, offset = low bits.

- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: lookup request.
- `req_addr` in ADDR_W: lookup address.
- `req_write` in 1: lookup is a store; sets dirty on hit.
- `req_ready` out 1: `~busy & ~fill_valid`.
- `fill_valid` in 1: install tag.
- `fill_addr` in ADDR_W: fill address (tag and set used).
- `fill_way` in WAY_W: way to write.
- `fill_dirty` in 1: initial dirty bit.
- `inv_all` in 1: start invalidate-all walk.
- `busy` out 1: walk in progress.
- `rsp_valid` out 1: response strobe, one cycle.
- `rsp_hit` out 1: tag matched a valid way.
- `rsp_way` out WAY_W: hit way on hit, victim way on miss.
- `rsp_victim_valid` out 1: victim way holds a valid line (miss only, else 0).
- `rsp_victim_tag` out TAG_W: victim tag (miss only, else 0).
- `rsp_victim_dirty` out 1: victim dirty (miss only, else 0).

## Operation
- **Storage:** per set and way, a tag, valid bit and dirty bit. Per set, one pLRU field:
  - 1 bit when `WAYS=2`: the bit names the victim way.
  - 3 bits `{b2,b1,b0}` when `WAYS=4`.
- **Lookup:** accepted on `req_valid & req_ready`. The set is read and compared in parallel across all ways.
  - Hit: `rsp_way` = matching way (lowest index if several match).
  - Miss: victim = lowest-index invalid way; if every way is valid, victim = pLRU way.
- **pLRU update on access to way w:**
  - `WAYS=2`: bit <= ~w.
  - `WAYS=4`: b0 <= ~w[1]. If w[1]=0 then b1 <= ~w[0], else b2 <= ~w[0].
  - `WAYS=4` victim = b0 ? {1,b2} : {0,b1}.
  - Updated on a hit and on a fill. Not updated on a miss.
- **Store hit:** sets dirty of the hit way.
- **Fill:** when `fill_valid` and not busy, the addressed set/way gets tag = fill tag, valid=1, dirty=`fill_dirty`, and a pLRU update. A fill during busy is dropped.
- **Walker FSM:**
  - States: IDLE, WALK.
  - IDLE -> WALK on `inv_all`; the set counter is cleared to 0.
  - Each WALK cycle clears valid, dirty and pLRU of set `counter`, then increments the counter.
  - WALK -> IDLE after set SETS-1 is cleared.
  - `inv_all` while in WALK is ignored.

## Timing
- **Lookup latency:** 1 cycle. `rsp_*` is registered on the edge that accepts the request and held for exactly one cycle. Otherwise `rsp_valid`=0 and `rsp_*` = 0.
- **Back-to-back:** one lookup per cycle. The second lookup sees the pLRU/dirty update of the first.
- **Fill:** state is written on the accepting edge. A lookup issued on the next cycle sees the new line.
- **Fill vs lookup collision:** lookup and fill cannot collide, because `req_ready` is low while `fill_valid` is high.
- **Walk:** `busy` rises the cycle after `inv_all` and stays high for exactly SETS cycles. `req_ready` is low throughout.
- **Reset:** FSM to IDLE, counter to 0. All valid, dirty and pLRU bits cleared. All outputs 0 except `req_ready`, which is 1 when `fill_valid`=0.
- **Reset mid-walk:** the walk aborts and everything is cleared in the same cycle.

## Configuration
- `CACHE_META_DIRTY_EN` defined: dirty bits are stored, set by store hits and by `fill_dirty`, and reported on `rsp_victim_dirty`.
- Not defined: no dirty storage; `req_write` and `fill_dirty` are ignored; `rsp_victim_dirty` is tied to 0 (write-through cache).

## Test plan
Defaults unless stated. Address 0x1234 decodes to tag 0x12, set 13.
1. After reset, lookup 0x1234 -> next cycle `rsp_valid`=1, hit=0, way=0, victim_valid=0, victim_tag=0.
2. Fill 0x1234 into way 0, then lookup 0x1234 -> hit, way 0. Lookup 0x5634 -> miss, way 1 (first invalid way), victim_valid=0.
3. Fill 0x5634 into way 1; lookup 0x1234 (hit, way 0); lookup 0x9A34 -> miss, way 1, victim_valid=1, victim_tag=0x56.
4. Continue from 3:
   - Store lookup 0x1234 with `req_write`=1 (hit, way 0), then lookup 0x5634 (hit, way 1).
   - Then lookup 0x9A34 -> miss, way 0, victim_tag=0x12.
   - `rsp_victim_dirty`=1 with `CACHE_META_DIRTY_EN` defined, 0 without it.
5. Pulse `inv_all`, then pulse it again during the walk -> `busy` high for exactly 64 cycles and `req_ready` low throughout. Afterwards lookup 0x1234 -> miss, victim_valid=0.
6. With `WAYS=4`:
   - Fill ways 0,1,2,3 of set 0 in order, then lookup a new tag -> miss, victim way 0.
   - Hit way 0, then lookup a new tag -> victim way 2.
